// File: rtl/imm_narrow_packer.sv
// Two-stage valid/ready packer narrowing signed IN_W values into OUT_W immediates.
// Build option: define IMM_SATURATE_EN to saturate non-fitting values instead of truncating.
module imm_narrow_packer #(
  parameter int IN_W  = 32,
  parameter int OUT_W = 16,
  parameter int TAG_W = 5,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [IN_W-1:0]  in_data,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OUT_W-1:0] out_imm,
  output logic             out_fits,
  output logic [TAG_W-1:0] out_tag,
  input  logic             ovf_clr,
  output logic [CNT_W-1:0] ovf_count,
  output logic             busy
);

  logic             s1_valid;
  logic [IN_W-1:0]  s1_data;
  logic [TAG_W-1:0] s1_tag;

  logic             s2_valid;
  logic [OUT_W-1:0] s2_imm;
  logic             s2_fits;
  logic [TAG_W-1:0] s2_tag;

  logic [CNT_W-1:0] cnt;

  logic             s2_load;
  logic [IN_W-OUT_W:0] upper;
  logic             fits;
  logic [OUT_W-1:0] imm;
  logic             ovf_xfer;

  assign s2_load  = !s2_valid || out_ready;
  assign in_ready = !s1_valid || s2_load;

  // The value fits when every bit from the OUT_W sign position upward agrees.
  assign upper = s1_data[IN_W-1:OUT_W-1];
  assign fits  = (&upper) | ~(|upper);

  always_comb begin
    imm = s1_data[OUT_W-1:0];
`ifdef IMM_SATURATE_EN
    if (!fits) begin
      imm = s1_data[IN_W-1] ? {1'b1, {(OUT_W-1){1'b0}}} : {1'b0, {(OUT_W-1){1'b1}}};
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_data  <= '0;
      s1_tag   <= '0;
    end else if (in_ready) begin
      s1_valid <= in_valid;
      if (in_valid) begin
        s1_data <= in_data;
        s1_tag  <= in_tag;
      end
    end
  end

  // Result registers only change when a new beat lands, so a stalled output holds steady.
  always_ff @(posedge clk) begin
    if (rst) begin
      s2_valid <= 1'b0;
      s2_imm   <= '0;
      s2_fits  <= 1'b0;
      s2_tag   <= '0;
    end else if (s2_load) begin
      s2_valid <= s1_valid;
      if (s1_valid) begin
        s2_imm  <= imm;
        s2_fits <= fits;
        s2_tag  <= s1_tag;
      end
    end
  end

  assign ovf_xfer = s2_valid && out_ready && !s2_fits;

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else if (ovf_clr) begin
      cnt <= '0;
    end else if (ovf_xfer && (cnt != {CNT_W{1'b1}})) begin
      cnt <= cnt + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

  assign out_valid = s2_valid;
  assign out_imm   = s2_imm;
  assign out_fits  = s2_fits;
  assign out_tag   = s2_tag;
  assign ovf_count = cnt;
  assign busy      = s1_valid || s2_valid;

endmodule

// File: tb/tb_imm_narrow_packer.sv
// Bench for imm_narrow_packer: queue-based reference model checked every cycle plus directed literal checks.
module tb_imm_narrow_packer;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_data;
  logic [4:0]  in_tag;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_imm;
  logic        out_fits;
  logic [4:0]  out_tag;
  logic        ovf_clr;
  logic [15:0] ovf_count;
  logic        busy;

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;

  imm_narrow_packer dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_tag(in_tag),
    .out_valid(out_valid), .out_ready(out_ready), .out_imm(out_imm),
    .out_fits(out_fits), .out_tag(out_tag),
    .ovf_clr(ovf_clr), .ovf_count(ovf_count), .busy(busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [15:0] imm;
    logic        fits;
    logic [4:0]  tag;
  } exp_t;

  exp_t        q[$];
  int unsigned mcount = 0;
  logic        held = 1'b0;
  exp_t        held_v;
  logic [15:0] log_imm[$];
  int          log_cyc[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference: fits iff the signed value lies in [-32768, 32767].
  function automatic exp_t model(input logic [31:0] d, input logic [4:0] t);
    exp_t e;
    int signed s;
    s = $signed(d);
    e.fits = (s >= -32768) && (s <= 32767);
    e.imm  = d[15:0];
`ifdef IMM_SATURATE_EN
    if (!e.fits) e.imm = (s < 0) ? 16'h8000 : 16'h7FFF;
`endif
    e.tag = t;
    return e;
  endfunction

  always @(negedge clk) begin
    if (rst) begin
      q.delete();
      mcount = 0;
      held = 1'b0;
    end else begin
      chk("busy", busy, q.size() != 0);
      chk("in_ready", in_ready, (q.size() < 2) || out_ready);
      chk("ovf_count", ovf_count, mcount);
      if (held) begin
        chk("hold_valid", out_valid, 1'b1);
        chk("hold_imm", out_imm, held_v.imm);
        chk("hold_fits", out_fits, held_v.fits);
        chk("hold_tag", out_tag, held_v.tag);
      end
      if (out_valid) begin
        if (q.size() == 0) begin
          chk("spurious_out_valid", out_valid, 1'b0);
        end else begin
          chk("out_imm", out_imm, q[0].imm);
          chk("out_fits", out_fits, q[0].fits);
          chk("out_tag", out_tag, q[0].tag);
        end
      end
      if (out_valid && out_ready && q.size() > 0) begin
        if (!q[0].fits && mcount != 32'hFFFF) mcount++;
        void'(q.pop_front());
      end
      if (ovf_clr) mcount = 0;
      held = out_valid && !out_ready;
      held_v.imm = out_imm;
      held_v.fits = out_fits;
      held_v.tag = out_tag;
      if (in_valid && in_ready) q.push_back(model(in_data, in_tag));
      if (out_valid && out_ready) begin
        log_imm.push_back(out_imm);
        log_cyc.push_back(cyc);
      end
    end
  end

  task automatic push(input logic [31:0] d, input logic [4:0] t);
    bit ok;
    ok = 0;
    in_valid = 1'b1;
    in_data = d;
    in_tag = t;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (in_ready) begin
        ok = 1;
        break;
      end
    end
    @(posedge clk);
    #1;
    if (!ok) chk("push_timeout", 32'd0, 32'd1);
  endtask

  task automatic send_wait(input logic [31:0] d, input logic [4:0] t,
                           input logic [15:0] eimm, input logic efits);
    bit seen;
    seen = 0;
    push(d, t);
    in_valid = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (out_valid) begin
        seen = 1;
        break;
      end
    end
    chk("lit_seen", seen, 1'b1);
    chk("lit_imm", out_imm, eimm);
    chk("lit_fits", out_fits, efits);
    chk("lit_tag", out_tag, t);
    @(posedge clk);
    #1;
  endtask

  initial begin
    #5_000_000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1;
    in_valid = 1'b0;
    in_data = '0;
    in_tag = '0;
    out_ready = 1'b1;
    ovf_clr = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    @(negedge clk);
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_in_ready", in_ready, 1'b1);
    chk("rst_ovf_count", ovf_count, 16'h0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_out_imm", out_imm, 16'h0);
    chk("rst_out_tag", out_tag, 5'd0);

    // Latency: accepted at edge N, out_valid visible after edge N+1, transfer at N+2.
    @(posedge clk); #1;
    in_valid = 1'b1; in_data = 32'h0000_7FFF; in_tag = 5'd3;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(negedge clk);
    chk("lat_not_yet", out_valid, 1'b0);
    @(negedge clk);
    chk("lat_valid", out_valid, 1'b1);
    chk("lat_imm", out_imm, 16'h7FFF);
    chk("lat_fits", out_fits, 1'b1);
    chk("lat_tag", out_tag, 5'd3);
    @(posedge clk); #1;

    send_wait(32'hFFFF_8000, 5'd4, 16'h8000, 1'b1);
    send_wait(32'hFFFF_FFFF, 5'd5, 16'hFFFF, 1'b1);
    @(negedge clk);
    chk("fit_ovf_zero", ovf_count, 16'h0);
    @(posedge clk); #1;
`ifdef IMM_SATURATE_EN
    send_wait(32'h0000_8000, 5'd6, 16'h7FFF, 1'b0);
    send_wait(32'hFFFF_7FFF, 5'd7, 16'h8000, 1'b0);
`else
    send_wait(32'h0000_8000, 5'd6, 16'h8000, 1'b0);
    send_wait(32'hFFFF_7FFF, 5'd7, 16'h7FFF, 1'b0);
`endif
    @(negedge clk);
    chk("ovf_two", ovf_count, 16'd2);
    @(posedge clk); #1;

    // Stall with both stages full, then drain in order without gaps.
    out_ready = 1'b0;
    push(32'h1, 5'd1);
    push(32'h2, 5'd2);
    in_data = 32'h3; in_tag = 5'd3;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk("stall_in_ready", in_ready, 1'b0);
      chk("stall_imm", out_imm, 16'h1);
    end
    log_imm.delete();
    log_cyc.delete();
    @(posedge clk); #1;
    out_ready = 1'b1;
    push(32'h3, 5'd3);
    push(32'h4, 5'd4);
    in_valid = 1'b0;
    repeat (4) @(negedge clk);
    chk("drain_count", log_imm.size(), 4);
    for (int i = 0; i < 4 && i < log_imm.size(); i++) begin
      chk("drain_order", log_imm[i], i + 1);
      if (i > 0) chk("drain_gap", log_cyc[i] - log_cyc[i-1], 1);
    end
    @(posedge clk); #1;

    for (int i = 0; i < 3; i++) push(32'h0001_0000 + i, 5'd9);
    in_valid = 1'b0;
    repeat (3) @(negedge clk);
    chk("ovf_five", ovf_count, 16'd5);
    @(posedge clk); #1;

    // Clear lands in the same cycle as a non-fitting transfer.
    push(32'h0002_0000, 5'd10);
    in_valid = 1'b0;
    @(posedge clk); #1;
    ovf_clr = 1'b1;
    @(negedge clk);
    chk("clr_xfer_valid", out_valid, 1'b1);
    chk("clr_xfer_fits", out_fits, 1'b0);
    @(posedge clk); #1;
    ovf_clr = 1'b0;
    @(negedge clk);
    chk("clr_priority", ovf_count, 16'h0);
    @(posedge clk); #1;

    for (int i = 0; i < 65540; i++) push(32'h4000_0000 | i, 5'd11);
    in_valid = 1'b0;
    repeat (3) @(negedge clk);
    chk("sat_reached", ovf_count, 16'hFFFF);
    @(posedge clk); #1;
    push(32'h8000_0000, 5'd12);
    in_valid = 1'b0;
    repeat (3) @(negedge clk);
    chk("sat_hold", ovf_count, 16'hFFFF);
    @(posedge clk); #1;

    // Reset with both stages full discards the held beats.
    out_ready = 1'b0;
    push(32'h55, 5'd13);
    push(32'h66, 5'd14);
    in_valid = 1'b0;
    @(negedge clk);
    chk("full_busy", busy, 1'b1);
    chk("full_in_ready", in_ready, 1'b0);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("mrst_out_valid", out_valid, 1'b0);
    chk("mrst_busy", busy, 1'b0);
    chk("mrst_in_ready", in_ready, 1'b1);
    chk("mrst_ovf_count", ovf_count, 16'h0);
    out_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("mrst_no_delivery", out_valid, 1'b0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/imm_narrow_packer.md
Name: imm_narrow_packer

Overview:
- Narrowing counterpart of the datapath's 16-to-32 immediate sign extension: converts 32-bit signed values back into 16-bit signed immediate fields.
- Used by the instruction-rewrite/encode path, e.g. branch-offset and immediate patching, before the field is written into the instruction word.
- Two-stage valid/ready pipeline with fit detection, tag pass-through and a saturating overflow event counter.

Parameters:
- IN_W, 32, width of the input value.
- OUT_W, 16, width of the immediate field produced.
- TAG_W, 5, width of the sideband tag carried alongside each value (e.g. destination register).
- CNT_W, 16, width of the overflow event counter.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous reset, active-high
- in_valid  input  1  input beat valid
- in_ready  output  1  block can accept an input beat this cycle
- in_data  input  IN_W  signed value to narrow
- in_tag  input  TAG_W  sideband tag, returned unchanged
- out_valid  output  1  output beat valid
- out_ready  input  1  consumer accepts the output beat
- out_imm  output  OUT_W  narrowed immediate field
- out_fits  output  1  1 = in_data representable in OUT_W signed bits
- out_tag  output  TAG_W  tag of the beat on out_imm
- ovf_clr  input  1  synchronous clear of ovf_count
- ovf_count  output  CNT_W  number of non-fitting beats delivered
- busy  output  1  any pipeline stage holds a valid beat

Behaviour:
- One clock and one reset. Reset is synchronous and active-high on rst; the clock is clk.
- Reset values:
  - in_ready = 1; out_valid = 0; out_imm = 0; out_fits = 0; out_tag = 0; ovf_count = 0; busy = 0.
  - Both stage valid bits are cleared.
- Reset mid-operation discards all in-flight beats. No output handshake occurs in the reset cycle.
- Handshakes:
  - Input transfer when in_valid && in_ready. Output transfer when out_valid && out_ready.
  - out_imm, out_fits and out_tag hold stable while out_valid && !out_ready.
  - out_valid never drops without a transfer, except on rst.
- Pipeline:
  - S1 registers in_data/in_tag. S2 registers the result.
  - Latency: an input accepted at edge N is presented with out_valid at edge N+2 when there is no stall. Throughput is 1 beat/cycle.
  - S2 loads when it is empty or out_ready=1. S1 advances when S2 loads. in_ready = !s1_valid || s2_load (combinational). in_valid must not combinationally depend on in_ready.
  - Order is strictly preserved, with no loss and no duplication.
- Fit rule (computed from the S1 value):
  - fits = 1 iff bits [IN_W-1:OUT_W-1] are all equal. With the defaults, bits 31..15 are all 0 or all 1.
  - If fits, out_imm = in_data[OUT_W-1:0]. Sign-extending out_imm reproduces in_data exactly.
  - If !fits, out_imm = in_data[OUT_W-1:0] (plain truncation) unless the Optional Feature is enabled.
- Counter:
  - ovf_count increments by 1 on each output transfer with out_fits = 0.
  - It saturates at all-ones and does not wrap.
  - ovf_clr has priority: if a clear and an increment occur in the same cycle, the result is 0.
- busy = s1_valid || s2_valid.

Optional Feature:
- Macro: IMM_SATURATE_EN.
- Defined: a non-fitting value saturates instead of truncating.
  - in_data[IN_W-1]=0 gives out_imm = 0x7FFF (max positive, OUT_W).
  - in_data[IN_W-1]=1 gives out_imm = 0x8000 (min negative).
  - out_fits is still 0 and ovf_count still increments.
- Undefined: plain truncation as described in Behaviour. Port list and latency are identical in both builds.

Test Plan:
- After reset, check out_valid=0, in_ready=1, ovf_count=0. Then send in_data=0x00007FFF, tag=3 at edge N -> at edge N+2: out_valid=1, out_imm=0x7FFF, out_fits=1, out_tag=3.
- in_data=0xFFFF8000 -> out_imm=0x8000, fits=1. in_data=0xFFFFFFFF -> out_imm=0xFFFF, fits=1. ovf_count stays 0.
- in_data=0x00008000 -> fits=0, out_imm=0x8000 (0x7FFF with IMM_SATURATE_EN). in_data=0xFFFF7FFF -> fits=0, out_imm=0x7FFF (0x8000 with macro). ovf_count=2.
- Hold out_ready=0 for 6 cycles while streaming 0x1,0x2,0x3,0x4 -> in_ready drops after 2 beats are accepted and the held output stays stable. Release out_ready -> beats emerge 0x1..0x4 in order, one per cycle, with no gaps or duplicates.
- ovf_count=5, then assert ovf_clr in the same cycle as a non-fitting output transfer -> ovf_count=0 next cycle. Force the counter to 0xFFFF, then deliver a non-fitting beat -> it stays 0xFFFF.
- Assert rst with both stages full -> next cycle out_valid=0, busy=0, in_ready=1, ovf_count=0. The previously held beats are never delivered.
